hazard_scoreboard: RTL and testbench

Parametrised successor to the decode-stage hazard detector. It tracks every architectural register with an in-flight write using a per-register countdown scoreboard. It also tracks writeback-port occupancy with a reservation shift register. From these it raises a stall for the instruction in D on either a RAW dependency or a writeback structural conflict. It supports variable producer latency (ALU, multiply, load), any number of source operands, and a hard-wired zero register. It sits in the decode stage and drives the IF/D write-enable and bubble-injection logic.

---
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detector: per-register countdown scoreboard plus writeback-slot reservations.
// Stall/issue are zero-cycle combinational; pend_any is registered and lags the counters by one cycle.
module hazard_scoreboard #(
  parameter int REG_ADDR = 5,
  parameter int NSRC     = 2,
  parameter int MAX_LAT  = 4,
  parameter int ZERO_REG = 1,
  parameter int WB_CHECK = 1,
  localparam int NREGS   = 2**REG_ADDR,
  localparam int LAT_W   = $clog2(MAX_LAT+1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     d_valid,
  input  logic [NSRC*REG_ADDR-1:0] d_src,
  input  logic [NSRC-1:0]          d_src_used,
  input  logic                     d_regwrite,
  input  logic [REG_ADDR-1:0]      d_dest_reg,
  input  logic [LAT_W-1:0]         d_latency,
  input  logic                     d_kill,
  output logic                     stall,
  output logic                     raw_stall,
  output logic                     wb_stall,
  output logic                     issue,
  output logic                     pend_any
);

  logic [LAT_W-1:0]    pend [NREGS];
  logic [MAX_LAT:1]    wb_resv;
  logic [LAT_W-1:0]    leff;
  logic [REG_ADDR-1:0] src;
  logic                d_live;
  logic                raw_hit;
  logic                wr;
  logic                pend_or;

  assign d_live = d_valid & ~d_kill;

  always_comb begin
    leff = d_latency;
    if (d_latency == '0)
      leff = LAT_W'(1);
    else if (d_latency > LAT_W'(MAX_LAT))
      leff = LAT_W'(MAX_LAT);
  end

  always_comb begin
    raw_hit = 1'b0;
    src     = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = d_src[i*REG_ADDR +: REG_ADDR];
      if (d_src_used[i] && (pend[src] != '0) && !((ZERO_REG != 0) && (src == '0)))
        raw_hit = 1'b1;
    end
  end

  assign raw_stall = d_live & raw_hit;
  assign wb_stall  = (WB_CHECK != 0) & d_live & d_regwrite & wb_resv[leff];
  assign stall     = raw_stall | wb_stall;
  assign issue     = d_live & ~stall;
  assign wr        = issue & d_regwrite;

  always_comb begin
    pend_or = 1'b0;
    for (int r = 0; r < NREGS; r++)
      pend_or = pend_or | (pend[r] != '0);
  end

  // A fresh write overrides any older count, so a short WAW wins over a long one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++)
        pend[r] <= '0;
      wb_resv  <= '0;
      pend_any <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr && (d_dest_reg == REG_ADDR'(r)) && !((ZERO_REG != 0) && (r == 0)))
          pend[r] <= leff;
        else if (pend[r] != '0)
          pend[r] <= pend[r] - LAT_W'(1);
      end
      // Latency-1 producers write back in the slot being consumed, so they reserve nothing.
      for (int i = 1; i < MAX_LAT; i++)
        wb_resv[i] <= wb_resv[i+1] | (wr && (leff == LAT_W'(i+1)));
      wb_resv[MAX_LAT] <= 1'b0;
      pend_any         <= pend_or;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset checks, and random traffic against a timeline model.
module tb_hazard_scoreboard;

  localparam int REG_ADDR = 5;
  localparam int NSRC     = 2;
  localparam int MAX_LAT  = 4;
  localparam int NREGS    = 2**REG_ADDR;
  localparam int LAT_W    = $clog2(MAX_LAT+1);

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     d_valid;
  logic [NSRC*REG_ADDR-1:0] d_src;
  logic [NSRC-1:0]          d_src_used;
  logic                     d_regwrite;
  logic [REG_ADDR-1:0]      d_dest_reg;
  logic [LAT_W-1:0]         d_latency;
  logic                     d_kill;
  logic                     stall, raw_stall, wb_stall, issue, pend_any;

  hazard_scoreboard #(
    .REG_ADDR(REG_ADDR), .NSRC(NSRC), .MAX_LAT(MAX_LAT), .ZERO_REG(1), .WB_CHECK(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_src(d_src),
    .d_src_used(d_src_used), .d_regwrite(d_regwrite), .d_dest_reg(d_dest_reg),
    .d_latency(d_latency), .d_kill(d_kill), .stall(stall), .raw_stall(raw_stall),
    .wb_stall(wb_stall), .issue(issue), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a register is readable from cycle ready_at[r]; wb_busy marks writeback cycles already taken.
  int ready_at [NREGS];
  bit wb_busy [int];
  int cyc = 0;
  logic exp_any = 1'b0;

  typedef struct {
    logic       v, k;
    int         s0, s1;
    logic [1:0] used;
    logic       rw;
    int         dest, lat;
    logic [4:0] exp;   // {raw_stall, wb_stall, stall, issue, pend_any}
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic v, input logic k, input int s0, input int s1,
                              input logic [1:0] used, input logic rw, input int dest,
                              input int lat, input logic [4:0] exp);
    vec_t t;
    t.v = v; t.k = k; t.s0 = s0; t.s1 = s1; t.used = used; t.rw = rw;
    t.dest = dest; t.lat = lat; t.exp = exp;
    return t;
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (raw,wb,stall,issue,pend_any)", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic k, input int s0, input int s1,
                       input logic [1:0] used, input logic rw, input int dest, input int lat);
    d_valid    = v;
    d_kill     = k;
    d_src      = {REG_ADDR'(s1), REG_ADDR'(s0)};
    d_src_used = used;
    d_regwrite = rw;
    d_dest_reg = REG_ADDR'(dest);
    d_latency  = LAT_W'(lat);
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
    wb_busy.delete();
    exp_any = 1'b0;
  endtask

  // One D-stage cycle: compare against the model at negedge, advance the model, step the clock.
  task automatic run_cycle(input string tag, output logic [4:0] got);
    int   leff, s;
    logic m_raw, m_wb, m_iss, live, now_any;
    @(negedge clk);
    leff = (d_latency == 0) ? 1 : ((int'(d_latency) > MAX_LAT) ? MAX_LAT : int'(d_latency));
    live = d_valid & ~d_kill;
    m_raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      s = int'(d_src[i*REG_ADDR +: REG_ADDR]);
      if (d_src_used[i] && s != 0 && cyc < ready_at[s]) m_raw = 1'b1;
    end
    m_raw = m_raw & live;
    m_wb  = live & d_regwrite & wb_busy.exists(cyc + leff);
    m_iss = live & ~m_raw & ~m_wb;
    got = {raw_stall, wb_stall, stall, issue, pend_any};
    check({tag, "/model"}, got, {m_raw, m_wb, m_raw | m_wb, m_iss, exp_any});
    now_any = 1'b0;
    for (int r = 0; r < NREGS; r++)
      if (cyc < ready_at[r]) now_any = 1'b1;
    if (m_iss && d_regwrite) begin
      if (d_dest_reg != 0) ready_at[d_dest_reg] = cyc + leff + 1;
      if (leff >= 2) wb_busy[cyc + leff] = 1'b1;
    end
    exp_any = now_any;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Asserts reset mid-cycle with state live; the scoreboard must clear at once.
  task automatic mid_reset(input string tag);
    logic [4:0] g;
    reset_n = 1'b0;
    #2;
    drive(1, 0, 4, 5, 2'b11, 1, 6, 3);
    #1;
    g = {raw_stall, wb_stall, stall, issue, pend_any};
    check({tag, "/in_reset"}, g, 5'b00010);
    @(posedge clk); cyc++; #1;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); cyc++; #1;
    model_clear();
  endtask

  logic [4:0] got;

  initial begin
    tbl[0]  = mk(1,0, 1,2, 2'b00, 1, 3,2, 5'b00010);
    tbl[1]  = mk(1,0, 3,0, 2'b01, 0, 0,1, 5'b10100);
    tbl[2]  = mk(1,0, 3,0, 2'b01, 0, 0,1, 5'b10101);
    tbl[3]  = mk(1,0, 3,0, 2'b01, 0, 0,1, 5'b00011);
    tbl[4]  = mk(1,0, 0,0, 2'b00, 1, 0,4, 5'b00010);
    tbl[5]  = mk(1,0, 0,0, 2'b11, 0, 0,1, 5'b00010);
    tbl[6]  = mk(0,0, 0,0, 2'b00, 0, 0,1, 5'b00000);
    tbl[7]  = mk(1,0, 1,2, 2'b00, 1, 5,3, 5'b00010);
    tbl[8]  = mk(1,0, 1,2, 2'b00, 1, 6,2, 5'b01100);
    tbl[9]  = mk(1,0, 1,2, 2'b00, 1, 6,2, 5'b00011);
    tbl[10] = mk(1,0, 1,2, 2'b00, 1, 7,4, 5'b00011);
    tbl[11] = mk(1,0, 1,2, 2'b00, 1, 7,1, 5'b00011);
    tbl[12] = mk(1,0, 7,0, 2'b01, 0, 0,1, 5'b10101);
    tbl[13] = mk(1,0, 7,0, 2'b01, 0, 0,1, 5'b00011);
    tbl[14] = mk(1,0, 1,2, 2'b00, 1, 9,4, 5'b00010);
    tbl[15] = mk(1,1, 9,0, 2'b01, 1,10,1, 5'b00000);
    tbl[16] = mk(1,0, 1,9, 2'b01, 0, 0,1, 5'b00011);
    tbl[17] = mk(1,0,10,0, 2'b01, 0, 0,1, 5'b00011);
    tbl[18] = mk(1,0, 1,9, 2'b10, 0, 0,1, 5'b10101);

    reset_n = 1'b0;
    drive(1, 0, 3, 4, 2'b11, 0, 0, 1);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {raw_stall, wb_stall, stall, issue, pend_any}, 5'b00010);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    cyc = 0;

    for (int n = 0; n < 19; n++) begin
      drive(tbl[n].v, tbl[n].k, tbl[n].s0, tbl[n].s1, tbl[n].used, tbl[n].rw, tbl[n].dest, tbl[n].lat);
      run_cycle($sformatf("vec%0d", n), got);
      check($sformatf("vec%0d/table", n), got, tbl[n].exp);
    end

    // Preload pending writes, then reset while they are still in flight.
    drive(1, 0, 0, 0, 2'b00, 1, 4, 4); run_cycle("preload_a", got);
    drive(1, 0, 0, 0, 2'b00, 1, 5, 3); run_cycle("preload_b", got);
    check("preload_pend", {1'b0, 1'b0, 1'b0, 1'b0, exp_any}, 5'b00001);
    mid_reset("reset_mid");
    drive(1, 0, 4, 5, 2'b11, 0, 0, 1);
    run_cycle("after_reset", got);
    check("after_reset/table", got, 5'b00010);

    for (int n = 0; n < 600; n++) begin
      if (n == 300) mid_reset("reset_rand");
      drive(($urandom_range(9) != 0), ($urandom_range(9) == 0),
            int'($urandom_range(7)), int'($urandom_range(7)), 2'($urandom_range(3)),
            ($urandom_range(9) < 7), int'($urandom_range(7)), int'($urandom_range(7)));
      run_cycle($sformatf("rand%0d", n), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
